// File: rtl/fetch_flow_ctrl_if.sv
// Fetch-stage hazard-control bus: hazard controls and fetch data in,
// PC / IF-ID register / counters out.
interface fetch_flow_ctrl_if;
  logic        pcWrite;
  logic        IFIDWrite;
  logic        ifNop;
  logic        ifFlush;
  logic [31:0] redirectTarget;
  logic [31:0] instrIn;
  logic [31:0] pc;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPcPlus4;
  logic        IFIDValid;
  logic        idexCtrlZero;
  logic [15:0] stallCount;
  logic [15:0] flushCount;
  logic        stallErr;

  // hazard unit / imem side
  modport master (
    output pcWrite, IFIDWrite, ifNop, ifFlush, redirectTarget, instrIn,
    input  pc, IFIDInstr, IFIDPcPlus4, IFIDValid, idexCtrlZero,
           stallCount, flushCount, stallErr
  );

  // fetch controller side
  modport slave (
    input  pcWrite, IFIDWrite, ifNop, ifFlush, redirectTarget, instrIn,
    output pc, IFIDInstr, IFIDPcPlus4, IFIDValid, idexCtrlZero,
           stallCount, flushCount, stallErr
  );
endinterface

// File: rtl/fetch_flow_ctrl.sv
// Fetch flow control: PC register, IF/ID pipeline register, stall/flush
// statistics and a stall-depth watchdog that latches an error on long stalls.
module fetch_flow_ctrl (
  input logic            clk,
  input logic            rst,
  fetch_flow_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, STALL1, STALL2, ERR} state_t;

  state_t      state_q, state_d;
  logic        stall, flush_eff;
  logic [31:0] pc_q, pc_plus4;
  logic [31:0] instr_q, pp4_q;
  logic        valid_q;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall_err;

  // a stalled PC cannot redirect, so a flush only counts when the PC moves
  assign stall     = ~bus.pcWrite;
  assign flush_eff = bus.ifFlush & bus.pcWrite;
  assign pc_plus4  = pc_q + 32'd4;

  // PC: redirect on effective flush, else advance, else hold
  always_ff @(posedge clk) begin
    if (rst)            pc_q <= '0;
    else if (flush_eff) pc_q <= bus.redirectTarget;
    else if (!stall)    pc_q <= pc_plus4;
  end

  // IF/ID register follows its own enable; a flush loads a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pp4_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.IFIDWrite) begin
      if (flush_eff) begin
        instr_q <= '0;
        pp4_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        instr_q <= bus.instrIn;
        pp4_q   <= pc_plus4;
        valid_q <= 1'b1;
      end
    end
  end

  // saturating stall / flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF)     stall_cnt <= stall_cnt + 16'd1;
      if (flush_eff && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  // watchdog state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // watchdog next state: three back-to-back stall cycles trap in ERR
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = stall ? STALL1 : RUN;
      STALL1:  state_d = stall ? STALL2 : RUN;
      STALL2:  state_d = stall ? ERR    : RUN;
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // watchdog output decode
  always_comb begin
    stall_err = 1'b0;
    if (state_q == ERR) stall_err = 1'b1;
  end

  assign bus.pc           = pc_q;
  assign bus.IFIDInstr    = instr_q;
  assign bus.IFIDPcPlus4  = pp4_q;
  assign bus.IFIDValid    = valid_q;
  assign bus.idexCtrlZero = ~bus.ifNop;
  assign bus.stallCount   = stall_cnt;
  assign bus.flushCount   = flush_cnt;
  assign bus.stallErr     = stall_err;
endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Bench for fetch_flow_ctrl: directed vector table, counter saturation run,
// then randomized traffic against a behavioural model.
module tb_fetch_flow_ctrl;
  logic clk = 1'b0;
  logic rst;
  fetch_flow_ctrl_if bus();

  fetch_flow_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, pw, iw, nop, fl;
    logic [31:0] tgt, instr;
    logic [31:0] e_pc, e_instr, e_pp4;
    bit          e_valid;
    logic [15:0] e_sc, e_fc;
    bit          e_err;
  } vec_t;

  vec_t vecs[22];
  int   checks = 0;
  int   errors = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_pp4;
  bit          m_valid, m_err;
  int          m_sc, m_fc, m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model one clock edge from the current inputs
  task automatic m_step();
    bit stall, fl;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0;
      m_sc = 0; m_fc = 0; m_run = 0; m_err = 0;
    end else begin
      stall = !bus.pcWrite;
      fl    = bus.ifFlush && bus.pcWrite;
      if (bus.IFIDWrite) begin
        if (fl) begin m_instr = 0; m_pp4 = 0; m_valid = 0; end
        else begin m_instr = bus.instrIn; m_pp4 = m_pc + 32'd4; m_valid = 1; end
      end
      if (fl)          m_pc = bus.redirectTarget;
      else if (!stall) m_pc = m_pc + 32'd4;
      if (stall && m_sc < 65535) m_sc++;
      if (fl && m_fc < 65535)    m_fc++;
      m_run = stall ? m_run + 1 : 0;
      if (m_run >= 3) m_err = 1;
    end
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, pw, iw, nop, fl, input logic [31:0] tgt, instr);
    rst = r; bus.pcWrite = pw; bus.IFIDWrite = iw; bus.ifNop = nop;
    bus.ifFlush = fl; bus.redirectTarget = tgt; bus.instrIn = instr;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},     bus.pc,          m_pc);
    chk({tag, ".instr"},  bus.IFIDInstr,   m_instr);
    chk({tag, ".pp4"},    bus.IFIDPcPlus4, m_pp4);
    chk({tag, ".valid"},  {31'd0, bus.IFIDValid}, {31'd0, m_valid});
    chk({tag, ".sc"},     {16'd0, bus.stallCount}, m_sc);
    chk({tag, ".fc"},     {16'd0, bus.flushCount}, m_fc);
    chk({tag, ".err"},    {31'd0, bus.stallErr}, {31'd0, m_err});
  endtask

  initial begin
    //         rst pw iw nop fl  tgt           instr          pc            instr         pp4          v  sc  fc  err
    vecs[0]  = '{1,0,0,1,1, 32'h80,       32'h0,        32'h0,        32'h0,        32'h0,  0, 0, 0, 0};
    vecs[1]  = '{0,1,1,1,0, 32'h0,        32'h11111111, 32'h4,        32'h11111111, 32'h4,  1, 0, 0, 0};
    vecs[2]  = '{0,1,1,1,0, 32'h0,        32'h11111111, 32'h8,        32'h11111111, 32'h8,  1, 0, 0, 0};
    vecs[3]  = '{0,1,1,1,0, 32'h0,        32'h11111111, 32'hC,        32'h11111111, 32'hC,  1, 0, 0, 0};
    vecs[4]  = '{0,1,1,1,0, 32'h0,        32'h22222222, 32'h10,       32'h22222222, 32'h10, 1, 0, 0, 0};
    vecs[5]  = '{0,1,1,1,1, 32'h40,       32'hDEADBEEF, 32'h40,       32'h0,        32'h0,  0, 0, 1, 0};
    vecs[6]  = '{0,1,1,1,0, 32'h0,        32'h33333333, 32'h44,       32'h33333333, 32'h44, 1, 0, 1, 0};
    vecs[7]  = '{0,1,1,1,1, 32'h1C,       32'hCAFEF00D, 32'h1C,       32'h0,        32'h0,  0, 0, 2, 0};
    vecs[8]  = '{0,1,1,1,0, 32'h0,        32'h44444444, 32'h20,       32'h44444444, 32'h20, 1, 0, 2, 0};
    vecs[9]  = '{0,0,0,0,0, 32'h0,        32'hBAD0BAD0, 32'h20,       32'h44444444, 32'h20, 1, 1, 2, 0};
    vecs[10] = '{0,0,0,0,0, 32'h0,        32'hBAD0BAD0, 32'h20,       32'h44444444, 32'h20, 1, 2, 2, 0};
    vecs[11] = '{0,1,1,1,0, 32'h0,        32'h55555555, 32'h24,       32'h55555555, 32'h24, 1, 2, 2, 0};
    vecs[12] = '{0,0,0,1,1, 32'h80,       32'h0,        32'h24,       32'h55555555, 32'h24, 1, 3, 2, 0};
    vecs[13] = '{0,1,0,1,0, 32'h0,        32'h12345678, 32'h28,       32'h55555555, 32'h24, 1, 3, 2, 0};
    vecs[14] = '{0,0,1,1,0, 32'h0,        32'h66666666, 32'h28,       32'h66666666, 32'h2C, 1, 4, 2, 0};
    vecs[15] = '{0,0,1,1,1, 32'h90,       32'h77777777, 32'h28,       32'h77777777, 32'h2C, 1, 5, 2, 0};
    vecs[16] = '{0,0,0,1,0, 32'h0,        32'h0,        32'h28,       32'h77777777, 32'h2C, 1, 6, 2, 1};
    vecs[17] = '{0,1,1,1,0, 32'h0,        32'h88888888, 32'h2C,       32'h88888888, 32'h2C, 1, 6, 2, 1};
    vecs[18] = '{1,0,1,1,1, 32'h100,      32'hFFFF,     32'h0,        32'h0,        32'h0,  0, 0, 0, 0};
    vecs[19] = '{0,1,1,1,0, 32'h0,        32'h99999999, 32'h4,        32'h99999999, 32'h4,  1, 0, 0, 0};
    vecs[20] = '{0,1,0,1,1, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 32'h99999999, 32'h4,  1, 0, 1, 0};
    vecs[21] = '{0,1,1,1,0, 32'h0,        32'hAAAAAAAA, 32'h0,        32'hAAAAAAAA, 32'h0,  1, 0, 1, 0};

    drive(1, 0, 0, 1, 0, 0, 0);
    #1;

    // directed vector table
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].pw, vecs[i].iw, vecs[i].nop, vecs[i].fl,
            vecs[i].tgt, vecs[i].instr);
      #1;
      chk($sformatf("v%0d.ctrl_zero", i), {31'd0, bus.idexCtrlZero}, {31'd0, !vecs[i].nop});
      cycle();
      chk($sformatf("v%0d.pc", i),    bus.pc,          vecs[i].e_pc);
      chk($sformatf("v%0d.instr", i), bus.IFIDInstr,   vecs[i].e_instr);
      chk($sformatf("v%0d.pp4", i),   bus.IFIDPcPlus4, vecs[i].e_pp4);
      chk($sformatf("v%0d.valid", i), {31'd0, bus.IFIDValid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d.sc", i),    {16'd0, bus.stallCount}, {16'd0, vecs[i].e_sc});
      chk($sformatf("v%0d.fc", i),    {16'd0, bus.flushCount}, {16'd0, vecs[i].e_fc});
      chk($sformatf("v%0d.err", i),   {31'd0, bus.stallErr}, {31'd0, vecs[i].e_err});
    end

    // stall counter saturation: 65536 consecutive stalls from reset
    drive(1, 0, 0, 1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 65534; i++) cycle();
    chk("sat.sc_fffe", {16'd0, bus.stallCount}, 32'hFFFE);
    cycle();
    chk("sat.sc_ffff", {16'd0, bus.stallCount}, 32'hFFFF);
    cycle();
    chk("sat.sc_hold", {16'd0, bus.stallCount}, 32'hFFFF);
    chk("sat.pc",      bus.pc, 32'h0);
    chk("sat.err",     {31'd0, bus.stallErr}, 32'h1);

    // randomized traffic against the model
    drive(1, 1, 1, 1, 0, 0, 0);
    cycle();
    chk_model("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(39) == 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
            $urandom_range(1), ($urandom_range(5) == 0),
            {$urandom} & 32'hFFFF_FFFC, $urandom);
      #1;
      chk("rnd.ctrl_zero", {31'd0, bus.idexCtrlZero}, {31'd0, !bus.ifNop});
      cycle();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
